// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives imem, and feeds decode via a 2-entry prefetch FIFO.
// Optional halt-on-zero-word behaviour is enabled by defining FETCH_HALT_ON_ZERO_EN.
module fetch_ctrl #(
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_q,
  input  logic          ready,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_pc,
  output logic          valid,
  output logic [31:0]   instr,
  output logic [N-1:0]  instr_pc,
  output logic          halted
);

  typedef enum logic [1:0] {FETCH, STALL, HALT} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  pc;
  logic [1:0]    count;
  logic [N-1:0]  pc0, pc1;
  logic [31:0]   w0, w1;
  logic          pop, push, zero_word;

  assign valid     = (count != 2'd0);
  assign pop       = valid & ready & ~redirect;
  assign imem_addr = pc[AW+1:2];
  assign instr     = valid ? w0  : '0;
  assign instr_pc  = valid ? pc0 : '0;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_word = (imem_q == 32'h0);
  assign halted    = (state == HALT);
`else
  assign zero_word = 1'b0;
  assign halted    = 1'b0;
`endif

  always_comb begin
    push      = 1'b0;
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if ((count < 2'd2) || pop) begin
          if (zero_word) state_nxt = HALT;
          else           push      = 1'b1;
        end else begin
          state_nxt = STALL;
        end
      end
      STALL:   if (pop) state_nxt = FETCH;
      HALT:    ;
      default: state_nxt = FETCH;
    endcase
    // Redirect overrides any push or state decision made above.
    if (redirect) begin
      push      = 1'b0;
      state_nxt = FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= '0;
      count <= '0;
      pc0   <= '0;
      pc1   <= '0;
      w0    <= '0;
      w1    <= '0;
    end else if (redirect) begin
      count <= '0;
      pc    <= redirect_pc & ~N'(3);
    end else begin
      if (push) pc <= pc + N'(4);
      // Entry 0 is always the head; a pop shifts entry 1 down.
      unique case ({pop, push})
        2'b10: begin
          pc0   <= pc1;
          w0    <= w1;
          count <= count - 2'd1;
        end
        2'b01: begin
          if (count == 2'd0) begin
            pc0 <= pc;
            w0  <= imem_q;
          end else begin
            pc1 <= pc;
            w1  <= imem_q;
          end
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            pc0 <= pc;
            w0  <= imem_q;
          end else begin
            pc0 <= pc1;
            w0  <= w1;
            pc1 <= pc;
            w1  <= imem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
